alarm_ring_ctrl: RTL

Sequencer for the alarm-output side of the alarm clock datapath. Decides when the alarm rings, snoozes, times out or is stopped, and drives the `Sound` line. Consumes the datapath's minute tick and its time-equals-alarm comparator output. Takes the user buttons `Snooze`, `Stop` and `Mute` directly, with no debounce in this block. Sits beside the setting control unit inside `datapath`.

---
 rtl/alarm_pkg.sv | 14 +
 rtl/edge_rise.sv | 21 ++
 rtl/alarm_ring_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared state encoding and parameter defaults for the alarm ring sequencer.
package alarm_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRing   = 2'b01,
        StSnooze = 2'b10
    } alarm_state_e;

    localparam int unsigned SnoozeMinDef  = 5;
    localparam int unsigned RingMaxMinDef = 10;
    localparam int unsigned ToneDivDef    = 4;

endpackage

// File: rtl/edge_rise.sv
// 1-bit rising-edge detector: pulses for the cycle a level first reads high.
module edge_rise (
    input  logic Clk,
    input  logic Reset,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm output sequencer: ring / snooze / auto-off / stop FSM, mute flag and
// buzzer tone generation. All outputs come straight from flops.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN   = SnoozeMinDef,
    parameter int unsigned RING_MAX_MIN = RingMaxMinDef,
    parameter int unsigned TONE_DIV     = ToneDivDef
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       min_tick,
    input  logic       match,
    input  logic       alarm_en,
    input  logic       Snooze,
    input  logic       Stop,
    input  logic       Mute,
    output logic       Sound,
    output logic       ringing,
    output logic       snoozing,
    output logic       muted,
    output logic [3:0] snooze_left
);

    localparam int unsigned ToneW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [ToneW-1:0] ToneLast = ToneW'(TONE_DIV - 1);
    localparam logic [3:0] RingLast  = 4'(RING_MAX_MIN - 1);
    localparam logic [3:0] SnoozeLd  = 4'(SNOOZE_MIN);

    logic w_match_rise;
    logic w_snooze_rise;
    logic w_stop_rise;
    logic w_mute_rise;

    edge_rise u_edge_match (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_level (match),
        .o_rise  (w_match_rise)
    );

    edge_rise u_edge_snooze (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_level (Snooze),
        .o_rise  (w_snooze_rise)
    );

    edge_rise u_edge_stop (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_level (Stop),
        .o_rise  (w_stop_rise)
    );

    edge_rise u_edge_mute (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_level (Mute),
        .o_rise  (w_mute_rise)
    );

    alarm_state_e     r_state;
    alarm_state_e     w_state_d;
    logic [3:0]       r_ring_cnt;
    logic [3:0]       w_ring_cnt_d;
    logic [3:0]       r_snooze_left;
    logic [3:0]       w_snooze_left_d;
    logic [ToneW-1:0] r_tone_cnt;
    logic [ToneW-1:0] w_tone_cnt_d;
    logic             r_tone;
    logic             w_tone_d;
    logic             r_muted;
    logic             w_muted_d;
    logic             r_sound;
    logic             w_sound_d;
    logic             r_ringing;
    logic             r_snoozing;
    logic             w_ring_entry;
    logic             w_ring_stay;

    // Next-state logic; the if/else chain encodes the transition priority.
    always_comb begin
        w_state_d = r_state;
        if (!alarm_en) begin
            w_state_d = StIdle;
        end else if (w_stop_rise && (r_state != StIdle)) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StRing: begin
                    if (w_snooze_rise) begin
                        w_state_d = StSnooze;
                    end else if (min_tick && (r_ring_cnt == RingLast)) begin
                        w_state_d = StIdle;
                    end
                end
                StSnooze: begin
                    if (min_tick && (r_snooze_left == 4'd1)) begin
                        w_state_d = StRing;
                    end
                end
                StIdle: begin
                    if (w_match_rise) begin
                        w_state_d = StRing;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_ring_entry    = (w_state_d == StRing) && (r_state != StRing);
        w_ring_stay     = (w_state_d == StRing) && (r_state == StRing);
        w_ring_cnt_d    = r_ring_cnt;
        w_snooze_left_d = r_snooze_left;
        w_tone_cnt_d    = '0;
        w_tone_d        = 1'b0;

        if (w_ring_entry) begin
            w_ring_cnt_d = 4'd0;
        end else if (w_ring_stay && min_tick) begin
            w_ring_cnt_d = r_ring_cnt + 4'd1;
        end

        if (w_state_d != StSnooze) begin
            w_snooze_left_d = 4'd0;
        end else if (r_state != StSnooze) begin
            w_snooze_left_d = SnoozeLd;
        end else if (min_tick) begin
            w_snooze_left_d = r_snooze_left - 4'd1;
        end

        // Tone starts high on RING entry and flips every TONE_DIV cycles.
        if (w_ring_entry) begin
            w_tone_cnt_d = '0;
            w_tone_d     = 1'b1;
        end else if (w_ring_stay) begin
            if (r_tone_cnt == ToneLast) begin
                w_tone_cnt_d = '0;
                w_tone_d     = ~r_tone;
            end else begin
                w_tone_cnt_d = r_tone_cnt + ToneW'(1);
                w_tone_d     = r_tone;
            end
        end

        w_muted_d = r_muted ^ w_mute_rise;
        w_sound_d = (w_state_d == StRing) & w_tone_d & ~w_muted_d;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= StIdle;
            r_ring_cnt    <= 4'd0;
            r_snooze_left <= 4'd0;
            r_tone_cnt    <= '0;
            r_tone        <= 1'b0;
            r_muted       <= 1'b0;
            r_sound       <= 1'b0;
            r_ringing     <= 1'b0;
            r_snoozing    <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_ring_cnt    <= w_ring_cnt_d;
            r_snooze_left <= w_snooze_left_d;
            r_tone_cnt    <= w_tone_cnt_d;
            r_tone        <= w_tone_d;
            r_muted       <= w_muted_d;
            r_sound       <= w_sound_d;
            r_ringing     <= (w_state_d == StRing);
            r_snoozing    <= (w_state_d == StSnooze);
        end
    end

    assign Sound       = r_sound;
    assign ringing     = r_ringing;
    assign snoozing    = r_snoozing;
    assign muted       = r_muted;
    assign snooze_left = r_snooze_left;

endmodule
